// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Fetch-stage widths, state encoding and IF/ID bundle.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  PC_STEP = 16'd2;
  localparam logic [INSTR_W-1:0] NOP     = 16'h0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;
  } if_id_t;

  function automatic logic [ADDR_W-1:0] pc_step(
    input logic [ADDR_W-1:0] pc
  );
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Flush only kills the valid bit; reset clears every field.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: next-PC mux, memory request FSM,
// stall hold buffer and IF/ID load control.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_in,
  output logic               pc_write,
  fetch_unit_if.master       imem,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [ADDR_W-1:0]  if_id_pc_next
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] hold;
  logic [ADDR_W-1:0]  hold_pc;
  logic [ADDR_W-1:0]  drain_addr;

  logic   load;
  logic   flush;
  if_id_t d;
  if_id_t q;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] hold_inc;
  logic              ready;

  assign pc_inc   = pc_step(pc_out);
  assign hold_inc = pc_step(hold_pc);
  assign ready    = imem.imem_ready;

  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_out;
    pc_write       = 1'b0;
    pc_in          = '0;
    load           = 1'b0;
    flush          = 1'b0;
    d              = '{1'b1, imem.imem_rdata, pc_out, pc_inc};
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          imem.imem_req = 1'b1;
          if (ready && !stall) begin
            load     = 1'b1;
            pc_write = 1'b1;
            pc_in    = pc_inc;
          end else if (!ready && !stall) begin
            flush = 1'b1;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load     = 1'b1;
            d        = '{1'b1, hold, hold_pc, hold_inc};
            pc_write = 1'b1;
            pc_in    = hold_inc;
          end
        end
        S_DRAIN: begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = drain_addr;
        end
        default: ;
      endcase
      // a redirect beats stall and any response arriving now
      if (branch_taken) begin
        load     = 1'b0;
        flush    = 1'b1;
        pc_write = 1'b1;
        pc_in    = branch_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      hold       <= '0;
      hold_pc    <= '0;
      drain_addr <= '0;
    end else if (branch_taken) begin
      unique case (state)
        S_FETCH: begin
          if (!ready) begin
            drain_addr <= pc_out;
            state      <= S_DRAIN;
          end
        end
        S_HOLD:  state <= S_FETCH;
        S_DRAIN: if (ready) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end else begin
      unique case (state)
        S_FETCH: begin
          if (ready && stall) begin
            hold    <= imem.imem_rdata;
            hold_pc <= pc_out;
            state   <= S_HOLD;
          end
        end
        S_HOLD:  if (!stall) state <= S_FETCH;
        S_DRAIN: if (ready) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .flush (flush),
    .d     (d),
    .q     (q)
  );

  assign if_id_valid   = q.valid;
  assign if_id_instr   = q.instr;
  assign if_id_pc      = q.pc;
  assign if_id_pc_next = q.pc_next;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC register + ROM environment,
// directed plan steps then random traffic vs a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_out;
  logic [15:0] pc_in;
  logic        pc_write;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        ready = 1'b1;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_next;

  int ncmp = 0;
  int nfail = 0;

  fetch_unit_if mem ();

  assign mem.imem_rdata = mem.imem_addr ^ 16'hA5A5;
  assign mem.imem_ready = ready;

  always #5 clk = ~clk;

  // architectural PC register that this stage drives
  always_ff @(posedge clk) begin
    if (rst) pc_out <= 16'h0;
    else if (pc_write) pc_out <= pc_in;
  end

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_out        (pc_out),
    .pc_in         (pc_in),
    .pc_write      (pc_write),
    .imem          (mem),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_id_valid   (if_id_valid),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_next (if_id_pc_next)
  );

  // reference model: expected PC, pending stalled instruction,
  // outstanding stale request, and decode-side view
  logic [15:0] m_pc = 0;
  bit          m_held = 0;
  logic [15:0] m_hpc = 0;
  bit          m_stale = 0;
  logic [15:0] m_saddr = 0;
  logic        m_v = 0;
  logic [15:0] m_ins = 0, m_ipc = 0, m_ipcn = 0;

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a ^ 16'hA5A5;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic deliver(input logic [15:0] a);
    m_v = 1; m_ins = rom(a); m_ipc = a; m_ipcn = a + 16'd2;
  endtask

  task automatic cyc(input logic r, input logic rd, input logic st,
                     input logic br, input logic [15:0] tgt);
    logic        e_req, e_pw;
    logic [15:0] e_addr, e_pin;
    @(negedge clk);
    rst = r; ready = rd; stall = st;
    branch_taken = br; branch_target = tgt;
    #1;
    e_req = 0; e_pw = 0; e_pin = 0;
    e_addr = m_stale ? m_saddr : m_pc;
    if (!r) begin
      e_req = !m_held;
      if (br) begin
        e_pw = 1; e_pin = tgt;
      end else if (m_held) begin
        e_pw = !st; e_pin = st ? 16'h0 : m_hpc + 16'd2;
      end else if (!m_stale && rd && !st) begin
        e_pw = 1; e_pin = m_pc + 16'd2;
      end
    end
    chk("imem_req", {15'b0, mem.imem_req}, {15'b0, e_req});
    if (e_req) chk("imem_addr", mem.imem_addr, e_addr);
    chk("pc_write", {15'b0, pc_write}, {15'b0, e_pw});
    if (e_pw || r) chk("pc_in", pc_in, e_pin);
    if (r) begin
      m_pc = 0; m_held = 0; m_stale = 0;
      m_v = 0; m_ins = 0; m_ipc = 0; m_ipcn = 0;
    end else if (br) begin
      m_v = 0;
      if (m_held) m_held = 0;
      else if (m_stale) m_stale = !rd;
      else if (!rd) begin m_stale = 1; m_saddr = m_pc; end
      m_pc = tgt;
    end else if (m_held) begin
      if (!st) begin
        deliver(m_hpc); m_held = 0; m_pc = m_hpc + 16'd2;
      end
    end else if (m_stale) begin
      if (rd) m_stale = 0;
    end else if (rd && !st) begin
      deliver(m_pc); m_pc = m_pc + 16'd2;
    end else if (rd) begin
      m_held = 1; m_hpc = m_pc;
    end else if (!st) begin
      m_v = 0;
    end
    @(posedge clk);
    #1;
    chk("if_id_valid", {15'b0, if_id_valid}, {15'b0, m_v});
    if (m_v || r) begin
      chk("if_id_instr", if_id_instr, m_ins);
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("if_id_pc_next", if_id_pc_next, m_ipcn);
    end
    chk("pc_reg", pc_out, m_pc);
  endtask

  initial begin
    logic        r, rd, st, br;
    logic [15:0] tgt;
    cyc(1, 1, 0, 0, 0);
    chk("rst_valid", {15'b0, if_id_valid}, 16'h0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("seq_pc", if_id_pc, 16'h0004);
    chk("seq_link", if_id_pc_next, 16'h0006);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("wait_pc", if_id_pc, 16'h0006);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("stall_pc", if_id_pc, 16'h0008);
    chk("stall_instr", if_id_instr, 16'h0008 ^ 16'hA5A5);
    cyc(0, 1, 0, 1, 16'h1234);
    chk("br_pc", pc_out, 16'h1234);
    cyc(0, 1, 0, 0, 0);
    chk("br_fetch", if_id_pc, 16'h1234);
    cyc(0, 0, 0, 1, 16'h5678);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("drain_valid", {15'b0, if_id_valid}, 16'h0);
    cyc(0, 1, 0, 0, 0);
    chk("drain_fetch", if_id_pc, 16'h5678);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 16'h0100);
    chk("brstall_valid", {15'b0, if_id_valid}, 16'h0);
    cyc(0, 0, 0, 1, 16'h0200);
    cyc(1, 0, 0, 0, 0);
    chk("midrst_pc", pc_out, 16'h0000);
    cyc(0, 1, 0, 0, 0);
    chk("restart_pc", if_id_pc, 16'h0000);
    cyc(0, 1, 0, 1, 16'hFFFE);
    cyc(0, 1, 0, 0, 0);
    chk("wrap_pc", if_id_pc, 16'hFFFE);
    chk("wrap_link", if_id_pc_next, 16'h0000);
    chk("wrap_next", pc_out, 16'h0000);
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rd  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 3) == 0);
      br  = ($urandom_range(0, 9) == 0);
      tgt = 16'($urandom) & 16'hFFFE;
      cyc(r, rd, st, br, tgt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
